spi_byte_rx: RTL and testbench
==============================

SPI_BYTE_RX -- requirements
Module: spi_byte_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per frame.
REQ-002 SHALL have parameter LSB_FIRST, default 1; 1 = first received bit lands in bit 0, 0 = first bit lands in bit DATA_W-1.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port spi_in  input  1  serial data line from transmitter.
REQ-006 SHALL have port spi_en  input  1  transmitter enable; high = frame in progress.
REQ-007 SHALL have port spi_clk  input  1  forwarded serial clock, asynchronous to clk.
REQ-008 SHALL have port data_out  output  DATA_W  last completed frame.
REQ-009 SHALL have port data_valid  output  1  data_out holds an unconsumed frame.
REQ-010 SHALL have port data_ready  input  1  consumer accepts data_out when high with data_valid.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse: completed frame dropped.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse: spi_en fell mid-frame.

Function
REQ-013 SHALL detect spi_clk rising edges as sampled spi_clk high this cycle and low the previous cycle; clk SHALL be >= 4x spi_clk.
REQ-014 SHALL use FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE: shift register and bit counter cleared; sampled spi_en high -> SHIFT.
REQ-016 SHIFT: on each detected edge with spi_en high, capture sampled spi_in per LSB_FIRST and increment bit counter (width $clog2(DATA_W)).
REQ-017 SHIFT: capture of bit DATA_W-1 -> DONE, counter wraps to 0.
REQ-018 SHIFT: sampled spi_en low with counter != 0 -> frame_err pulse, partial data discarded, -> IDLE; with counter == 0 -> IDLE, no error.
REQ-019 DONE (one cycle): if data_valid low or data_ready high, load data_out, set data_valid; else assert overrun, keep data_out unchanged; then -> SHIFT if spi_en high, else IDLE.
REQ-020 data_valid SHALL rise exactly 1 clk after the cycle in which the last bit edge is detected.
REQ-021 data_valid SHALL clear on data_valid && data_ready unless a DONE load occurs the same cycle, in which case data_valid stays high with the new frame.
REQ-022 Back-to-back frames with spi_en held high SHALL be received without lost bits.
REQ-023 spi_clk edges while spi_en low SHALL be ignored.

Reset
REQ-024 rst high SHALL immediately force state IDLE, counter 0, shift register 0, data_out 0, data_valid 0, overrun 0, frame_err 0, synchronizer flops 0.
REQ-025 rst mid-frame SHALL discard the partial frame without frame_err; reception resumes at the next spi_en assertion after release.

Configuration
REQ-026 Macro SPI_RX_SYNC_EN defined: spi_clk, spi_en, spi_in each pass through a 2-flop synchronizer before use, adding 2 clk of latency to REQ-020.
REQ-027 SPI_RX_SYNC_EN undefined: inputs sampled through a single register stage; use only when the transmitter shares clk.

Structure
REQ-028 Package spi_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE) and the constant SPI_DATA_W = 8, shared with the transmitter.
REQ-029 Sub-module spi_rx_sync (parameterised-width 2-flop synchronizer, async active-high reset) SHALL be instantiated only under SPI_RX_SYNC_EN.

Verification
REQ-030 Send 0xA5 LSB-first, data_ready held high -> data_out = 0xA5, data_valid high 1 cycle after the 8th edge (plus 2 with SPI_RX_SYNC_EN).
REQ-031 LSB_FIRST=0, send bits 1,0,0,0,0,0,0,1 -> data_out = 0x81.
REQ-032 Frames 0x3C then 0xC3 with spi_en held high, data_ready high -> two valid frames in order, no overrun, no frame_err.
REQ-033 data_ready low, send 0x11 then 0x22 -> data_out stays 0x11, overrun pulses once when 0x22 completes.
REQ-034 Drop spi_en after 5 bits, then send 0x7E -> frame_err pulses once, next frame data_out = 0x7E.
REQ-035 Assert rst after 4 bits of 0xFF, release, send 0x0F -> all outputs 0 during reset, no frame_err, data_out = 0x0F.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI byte receiver and transmitter.
// Holds the receiver FSM state encoding, the default frame width and a
// small helper for sizing the bit counter.
package spi_pkg;

    // Default frame width shared with the transmitter side.
    localparam int SPI_DATA_W = 8;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_t;

    // Width of a counter that indexes bits 0..data_w-1 (at least 1 bit).
    function automatic int spi_cnt_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage : spi_pkg

// File: rtl/spi_rx_sync.sv
// spi_rx_sync: parameterised-width two-flop synchronizer with asynchronous
// active-high reset. Only compiled when SPI_RX_SYNC_EN is defined, which is
// also the only build that instantiates it.
`ifdef SPI_RX_SYNC_EN
module spi_rx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops per bit to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : spi_rx_sync
`endif

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: oversampling SPI frame receiver.
// Samples spi_clk/spi_en/spi_in on clk, detects spi_clk rising edges and
// shifts DATA_W bits into a frame. Completed frames are presented on
// data_out with a valid/ready handshake; a frame that completes while the
// previous one is still unconsumed is dropped and flagged with overrun.
// Dropping spi_en mid-frame discards the partial frame and pulses frame_err.
//
// Build option: define SPI_RX_SYNC_EN to route the serial inputs through a
// two-flop synchronizer (spi_rx_sync) ahead of the sampling register, for a
// transmitter clocked independently of clk. Without it the inputs pass
// through a single register stage and must be synchronous to clk.
module spi_byte_rx
    import spi_pkg::*;
#(
    parameter int DATA_W    = SPI_DATA_W,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_in,
    input  logic              spi_en,
    input  logic              spi_clk,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overrun,
    output logic              frame_err
);

    localparam int               CNT_W    = spi_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // Serial inputs after the optional synchronizer: {spi_clk, spi_en, spi_in}.
    logic [2:0]        raw_in;

    // Sampled copies used by the rest of the design.
    logic              spi_clk_s;
    logic              spi_en_s;
    logic              spi_in_s;
    logic              spi_clk_d;
    logic              clk_rise;

    spi_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic              load_ok;

`ifdef SPI_RX_SYNC_EN
    logic [2:0] sync_q;

    spi_rx_sync #(
        .WIDTH (3)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({spi_clk, spi_en, spi_in}),
        .q   (sync_q)
    );

    assign raw_in = sync_q;
`else
    assign raw_in = {spi_clk, spi_en, spi_in};
`endif

    // Sampling register plus a delayed copy of spi_clk for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_clk_s <= 1'b0;
            spi_en_s  <= 1'b0;
            spi_in_s  <= 1'b0;
            spi_clk_d <= 1'b0;
        end else begin
            spi_clk_s <= raw_in[2];
            spi_en_s  <= raw_in[1];
            spi_in_s  <= raw_in[0];
            spi_clk_d <= spi_clk_s;
        end
    end

    // Rising edge: sampled spi_clk high now, low in the previous cycle.
    assign clk_rise = spi_clk_s & ~spi_clk_d;

    // Next shift-register value when a bit is captured, honouring bit order.
    always_comb begin
        shift_next = shift_reg;
        if (LSB_FIRST != 0) begin
            shift_next = {spi_in_s, shift_reg[DATA_W-1:1]};
        end else begin
            shift_next = {shift_reg[DATA_W-2:0], spi_in_s};
        end
    end

    // A finished frame may be loaded if the output slot is free or being consumed.
    assign load_ok = ~data_valid | data_ready;

    // Receiver FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;

            // Consumption; a DONE load below in the same cycle takes precedence.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                    if (spi_en_s) begin
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (!spi_en_s) begin
                        if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                    end else if (clk_rise) begin
                        shift_reg <= shift_next;
                        if (bit_cnt == CNT_LAST) begin
                            bit_cnt <= '0;
                            state   <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (load_ok) begin
                        data_out   <= shift_reg;
                        data_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                    state <= spi_en_s ? SHIFT : IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : spi_byte_rx

// File: tb/tb_spi_byte_rx.sv
// tb_spi_byte_rx: directed self-checking bench for spi_byte_rx.
// Two receivers share the serial stimulus: one LSB-first, one MSB-first.
// Each sent frame pushes its expected value into a per-receiver queue; a
// monitor pops and compares whenever a frame is consumed.
module tb_spi_byte_rx;

`ifdef SPI_RX_SYNC_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_in;
    logic       spi_en;
    logic       spi_clk;
    logic       data_ready;

    logic [7:0] dout_l;
    logic       dv_l;
    logic       ovr_l;
    logic       fe_l;
    logic [7:0] dout_m;
    logic       dv_m;
    logic       ovr_m;
    logic       fe_m;

    int checks = 0;
    int errors = 0;
    int ovr_cnt_l = 0;
    int fe_cnt_l  = 0;
    int ovr_cnt_m = 0;
    int fe_cnt_m  = 0;
    int lat;

    logic [7:0] q_l[$];
    logic [7:0] q_m[$];

    always #5 clk = ~clk;

    spi_byte_rx #(
        .DATA_W    (8),
        .LSB_FIRST (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_in     (spi_in),
        .spi_en     (spi_en),
        .spi_clk    (spi_clk),
        .data_out   (dout_l),
        .data_valid (dv_l),
        .data_ready (data_ready),
        .overrun    (ovr_l),
        .frame_err  (fe_l)
    );

    spi_byte_rx #(
        .DATA_W    (8),
        .LSB_FIRST (0)
    ) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .spi_in     (spi_in),
        .spi_en     (spi_en),
        .spi_clk    (spi_clk),
        .data_out   (dout_m),
        .data_valid (dv_m),
        .data_ready (data_ready),
        .overrun    (ovr_m),
        .frame_err  (fe_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    // Send nbits of v, v[0] first; spi_clk low 2 clk then high 2 clk per bit.
    // With hold=0 the task returns right after the last rising edge is driven.
    task automatic send_bits(input logic [7:0] v, input int nbits, input bit push, input bit hold);
        if (push) begin
            q_l.push_back(v);
            q_m.push_back(rev8(v));
        end
        for (int i = 0; i < nbits; i++) begin
            spi_in  = v[i];
            spi_clk = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            spi_clk = 1'b1;
            if (hold || i != nbits - 1) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
    endtask

    // Scoreboard monitor and pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (ovr_l) ovr_cnt_l++;
            if (fe_l)  fe_cnt_l++;
            if (ovr_m) ovr_cnt_m++;
            if (fe_m)  fe_cnt_m++;
            if (dv_l && data_ready) begin
                chk("sb_l_pending", 32'(q_l.size() != 0), 32'd1);
                if (q_l.size() != 0) chk("sb_l_data", 32'(dout_l), 32'(q_l.pop_front()));
            end
            if (dv_m && data_ready) begin
                chk("sb_m_pending", 32'(q_m.size() != 0), 32'd1);
                if (q_m.size() != 0) chk("sb_m_data", 32'(dout_m), 32'(q_m.pop_front()));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        spi_in     = 1'b0;
        spi_en     = 1'b0;
        spi_clk    = 1'b0;
        data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out",   32'(dout_l), 32'h0);
        chk("rst_data_valid", 32'(dv_l),   32'h0);
        chk("rst_overrun",    32'(ovr_l),  32'h0);
        chk("rst_frame_err",  32'(fe_l),   32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 0xA5 LSB-first, with valid latency measured from the last edge
        spi_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_bits(8'hA5, 8, 1'b1, 1'b0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (dv_l) break;
        end
        chk("a5_latency", 32'(lat), 32'(LAT));
        chk("a5_data",    32'(dout_l), 32'hA5);
        repeat (3) @(posedge clk);
        #1;
        spi_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // spi_clk toggling with spi_en low must be ignored
        send_bits(8'hFF, 8, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("idle_edges_valid", 32'(dv_l),     32'h0);
        chk("idle_edges_ferr",  32'(fe_cnt_l), 32'd0);

        // bits 1,0,0,0,0,0,0,1: MSB-first receiver must hold 0x81
        spi_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_bits(8'h81, 8, 1'b1, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("msb_81_data", 32'(dout_m), 32'h81);

        // back-to-back 0x3C, 0xC3 with spi_en held high
        send_bits(8'h3C, 8, 1'b1, 1'b1);
        send_bits(8'hC3, 8, 1'b1, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        spi_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_overrun",  32'(ovr_cnt_l), 32'd0);
        chk("b2b_ferr",     32'(fe_cnt_l),  32'd0);
        chk("b2b_drained",  32'(q_l.size()), 32'd0);
        chk("b2b_last",     32'(dout_l),    32'hC3);

        // overrun: consumer stalled, 0x11 kept, 0x22 dropped
        data_ready = 1'b0;
        spi_en     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_bits(8'h11, 8, 1'b1, 1'b1);
        send_bits(8'h22, 8, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        spi_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_data_kept", 32'(dout_l),    32'h11);
        chk("ovr_msb_kept",  32'(dout_m),    32'h88);
        chk("ovr_valid",     32'(dv_l),      32'h1);
        chk("ovr_count",     32'(ovr_cnt_l), 32'd1);
        data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ovr_consumed",  32'(dv_l),       32'h0);
        chk("ovr_drained",   32'(q_l.size()), 32'd0);

        // frame error: spi_en drops after 5 bits, then 0x7E
        spi_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_bits(8'h1F, 5, 1'b0, 1'b1);
        spi_en = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("ferr_count", 32'(fe_cnt_l), 32'd1);
        chk("ferr_valid", 32'(dv_l),     32'h0);
        spi_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_bits(8'h7E, 8, 1'b1, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        spi_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ferr_next_data", 32'(dout_l),   32'h7E);
        chk("ferr_once",      32'(fe_cnt_l), 32'd1);

        // reset mid-frame after 4 bits of 0xFF, then 0x0F
        spi_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_bits(8'hFF, 4, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_data_out",  32'(dout_l), 32'h0);
        chk("midrst_msb_out",   32'(dout_m), 32'h0);
        chk("midrst_valid",     32'(dv_l),   32'h0);
        chk("midrst_overrun",   32'(ovr_l),  32'h0);
        chk("midrst_frame_err", 32'(fe_l),   32'h0);
        spi_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        spi_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_bits(8'h0F, 8, 1'b1, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        spi_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("postrst_data", 32'(dout_l),   32'h0F);
        chk("postrst_ferr", 32'(fe_cnt_l), 32'd1);

        // final scoreboard and pulse totals
        repeat (10) @(posedge clk);
        #1;
        chk("final_q_l",   32'(q_l.size()), 32'd0);
        chk("final_q_m",   32'(q_m.size()), 32'd0);
        chk("final_ovr_m", 32'(ovr_cnt_m),  32'd1);
        chk("final_fe_m",  32'(fe_cnt_m),   32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spi_byte_rx
